// File: rtl/search_scheduler_pkg.sv
// search_scheduler_pkg
// Shared constants for the search scheduler slice.
//   DEFAULT_CODE_W : default width of codes and result lengths
//   MAX_N          : largest accepted code length in bits
//   S_*            : scheduler FSM state encodings
//   last_code_for  : highest code of an n-bit run, in 9-bit arithmetic
package search_scheduler_pkg;

  localparam int DEFAULT_CODE_W = 8;
  localparam logic [3:0] MAX_N = 4'd8;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DISPATCH = 2'd1;
  localparam logic [1:0] S_DRAIN    = 2'd2;
  localparam logic [1:0] S_FINISH   = 2'd3;

  // Nine bits so that n=8 gives 255 without overflowing the shift.
  function automatic logic [8:0] last_code_for(input logic [3:0] n);
    return (9'd1 << n) - 9'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational round-robin selector: finds the first idle worker at or
// after the pointer rr, wrapping around to the lowest idle index.
//   busy  : per-worker busy flags
//   rr    : round-robin start index
//   valid : at least one worker is idle
//   idx   : index of the chosen idle worker (meaningful when valid)
module rr_pick
  import search_scheduler_pkg::*;
#(
  parameter int NUM_WORKERS = 4,
  parameter int IDX_W       = 2
) (
  input  logic [NUM_WORKERS-1:0] busy,
  input  logic [IDX_W-1:0]       rr,
  output logic                   valid,
  output logic [IDX_W-1:0]       idx
);

  logic             wrap_valid;
  logic             ahead_valid;
  logic [IDX_W-1:0] wrap_idx;
  logic [IDX_W-1:0] ahead_idx;

  // Scanning downwards leaves the lowest matching index in each candidate:
  // "ahead" only considers indices >= rr, "wrap" considers all of them and
  // is used when nothing at or after the pointer is free.
  always_comb begin
    wrap_valid  = 1'b0;
    wrap_idx    = '0;
    ahead_valid = 1'b0;
    ahead_idx   = '0;
    for (int i = NUM_WORKERS - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        wrap_valid = 1'b1;
        wrap_idx   = IDX_W'(i);
        if (i >= int'(rr)) begin
          ahead_valid = 1'b1;
          ahead_idx   = IDX_W'(i);
        end
      end
    end
  end

  assign valid = wrap_valid;
  assign idx   = ahead_valid ? ahead_idx : wrap_idx;

endmodule

// File: rtl/search_scheduler.sv
// search_scheduler
// Hands out the codes 0 .. 2^n-1 to a pool of search workers, collects
// their result lengths and keeps the best (longest, lowest code on ties).
//   clock, reset    : clock and synchronous active-high reset
//   go, n           : start pulse and code length (1..8 valid)
//   busy, done      : run in progress / one-cycle end-of-run pulse
//   worker_start    : one-hot start pulse to a worker
//   worker_code     : code handed out with worker_start
//   worker_complete : per-worker completion pulses
//   worker_result   : per-worker result lengths, CODE_W bits each
//   best_code       : code that produced the best result
//   best_len        : best result length
module search_scheduler
  import search_scheduler_pkg::*;
#(
  parameter int NUM_WORKERS = 4,
  parameter int CODE_W      = DEFAULT_CODE_W
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          go,
  input  logic [3:0]                    n,
  output logic                          busy,
  output logic                          done,
  output logic [NUM_WORKERS-1:0]        worker_start,
  output logic [CODE_W-1:0]             worker_code,
  input  logic [NUM_WORKERS-1:0]        worker_complete,
  input  logic [NUM_WORKERS*CODE_W-1:0] worker_result,
  output logic [CODE_W-1:0]             best_code,
  output logic [CODE_W-1:0]             best_len
);

  localparam int IDX_W = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;

  logic [1:0]             state;
  logic [8:0]             next_code;
  logic [8:0]             last_code;
  logic [IDX_W-1:0]       rr;
  logic [NUM_WORKERS-1:0] worker_busy;
  logic [NUM_WORKERS-1:0] worker_pending;
  logic [CODE_W-1:0]      code_store   [NUM_WORKERS];
  logic [CODE_W-1:0]      result_store [NUM_WORKERS];

  logic                   pick_valid;
  logic [IDX_W-1:0]       pick_idx;
  logic                   cons_valid;
  logic [IDX_W-1:0]       cons_idx;
  logic [CODE_W-1:0]      cons_result;
  logic [CODE_W-1:0]      cons_code;
  logic                   take_result;

  rr_pick #(
    .NUM_WORKERS(NUM_WORKERS),
    .IDX_W      (IDX_W)
  ) u_rr_pick (
    .busy (worker_busy),
    .rr   (rr),
    .valid(pick_valid),
    .idx  (pick_idx)
  );

  // Lowest-index pending result is consumed first, one per cycle.
  always_comb begin
    cons_valid = 1'b0;
    cons_idx   = '0;
    for (int i = NUM_WORKERS - 1; i >= 0; i--) begin
      if (worker_pending[i]) begin
        cons_valid = 1'b1;
        cons_idx   = IDX_W'(i);
      end
    end
  end

  assign cons_result = result_store[cons_idx];
  assign cons_code   = code_store[cons_idx];
  assign take_result = cons_valid &&
                       ((cons_result > best_len) ||
                        ((cons_result == best_len) && (cons_code < best_code)));

  // Run control, dispatch, result capture and best tracking. Dispatch only
  // targets non-busy workers and consumption only frees busy ones, so the
  // two never touch the same worker flag in one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      worker_start   <= '0;
      worker_code    <= '0;
      best_code      <= '0;
      best_len       <= '0;
      next_code      <= '0;
      last_code      <= '0;
      rr             <= '0;
      worker_busy    <= '0;
      worker_pending <= '0;
      for (int i = 0; i < NUM_WORKERS; i++) begin
        code_store[i]   <= '0;
        result_store[i] <= '0;
      end
    end else begin
      worker_start <= '0;
      done         <= 1'b0;

      case (state)
        S_IDLE: begin
          if (go) begin
            best_code <= '0;
            best_len  <= '0;
            if ((n != 4'd0) && (n <= MAX_N)) begin
              state     <= S_DISPATCH;
              busy      <= 1'b1;
              next_code <= '0;
              last_code <= last_code_for(n);
            end else begin
              state <= S_FINISH;
            end
          end
        end
        S_DISPATCH: begin
          if (pick_valid) begin
            worker_start[pick_idx] <= 1'b1;
            worker_busy[pick_idx]  <= 1'b1;
            worker_code            <= CODE_W'(next_code);
            code_store[pick_idx]   <= CODE_W'(next_code);
            next_code              <= next_code + 9'd1;
            rr <= (pick_idx == IDX_W'(NUM_WORKERS - 1)) ? '0 : pick_idx + 1'b1;
            if (next_code == last_code) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if ((worker_busy == '0) && (worker_pending == '0)) begin
            state <= S_FINISH;
          end
        end
        default: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase

      for (int i = 0; i < NUM_WORKERS; i++) begin
        if (worker_complete[i] && worker_busy[i] && !worker_pending[i]) begin
          worker_pending[i] <= 1'b1;
          result_store[i]   <= worker_result[i*CODE_W +: CODE_W];
        end
      end

      if (cons_valid) begin
        worker_pending[cons_idx] <= 1'b0;
        worker_busy[cons_idx]    <= 1'b0;
        if (take_result) begin
          best_len  <= cons_result;
          best_code <= cons_code;
        end
      end
    end
  end

endmodule

// File: doc/search_scheduler.md
SEARCH_SCHEDULER -- requirements
Module: search_scheduler

Interface
REQ-001 Parameter NUM_WORKERS, default 4, number of attached search workers (1..8).
REQ-002 Parameter CODE_W, default 8, width of codes and result lengths.
REQ-003 clock  input  1  sole clock; all logic on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 go  input  1  one-cycle pulse that starts a run.
REQ-006 n  input  4  code length in bits; sampled on accepted go.
REQ-007 busy  output  1  high from accepted go until done.
REQ-008 done  output  1  one-cycle pulse at run end.
REQ-009 worker_start  output  NUM_WORKERS  one-cycle start pulse, one bit per worker.
REQ-010 worker_code  output  CODE_W  start code; valid in the cycle of any worker_start bit.
REQ-011 worker_complete  input  NUM_WORKERS  one-cycle completion pulse per worker.
REQ-012 worker_result  input  NUM_WORKERS*CODE_W  per-worker result length; slice i valid with worker_complete[i].
REQ-013 best_code  output  CODE_W  start code of the best result; stable after done until next accepted go.
REQ-014 best_len  output  CODE_W  best result length; stable after done until next accepted go.

Function
REQ-015 States: IDLE, DISPATCH, DRAIN, FINISH; reset enters IDLE.
REQ-016 IDLE: go=1 with 1<=n<=8 -> DISPATCH; clear best_code/best_len, next_code=0, last_code=2^n-1 (9-bit arithmetic); busy=1 next cycle.
REQ-017 IDLE: go=1 with n=0 or n>8 -> FINISH with best_len=0, best_code=0, no worker_start.
REQ-018 go while busy is ignored.
REQ-019 DISPATCH: at most one worker_start bit per cycle, to the first idle worker at or after round-robin pointer rr; worker_code=next_code; that worker marked busy and its code stored; next_code++; rr=chosen index+1 mod NUM_WORKERS.
REQ-020 First worker_start occurs exactly 1 cycle after the state transition out of IDLE (go at cycle t -> start at t+2).
REQ-021 DISPATCH -> DRAIN in the cycle that dispatches code last_code.
REQ-022 worker_complete[i] with worker i busy and no result pending: latch worker_result slice i, set pending[i]; complete for a non-busy or already-pending worker is ignored.
REQ-023 Any number of completes in one cycle are all latched.
REQ-024 One pending result consumed per cycle, lowest index first; consumption clears pending[i] and busy[i] in the same cycle; worker is not re-dispatched before then.
REQ-025 Update rule: result>best_len, or result==best_len and stored code<best_code -> replace best_len/best_code; a first result is always taken if best_len=0 and best_code=0 only by the same rule (result 0 keeps code 0).
REQ-026 Dispatch and consumption may occur in the same cycle; a worker freed in cycle c is eligible for dispatch in cycle c+1.
REQ-027 DRAIN -> FINISH when no worker busy and no result pending.
REQ-028 FINISH: done=1 for one cycle, busy=0 in that cycle, -> IDLE.
REQ-029 n=8 dispatches all 256 codes; next_code never wraps into a repeat dispatch.

Reset
REQ-030 Reset values: busy=0, done=0, worker_start=0, worker_code=0, best_code=0, best_len=0, rr=0, all busy/pending flags 0, state IDLE.
REQ-031 Reset mid-run aborts immediately; no worker_start or done in the reset cycle or after, until a new go; completes arriving after reset are ignored.

Structure
REQ-032 State encodings and CODE_W/MAX_N constants live in the shared search package.
REQ-033 One sub-module: rr_pick (round-robin first-idle selector, combinational, NUM_WORKERS-wide).

Verification
REQ-034 NUM_WORKERS=4, n=2, workers complete 3 cycles after start with results {2,5,5,1} for codes 0..3 -> 4 starts, codes 0,1,2,3, best_code=1, best_len=5, single done pulse.
REQ-035 n=3, all 4 workers complete in the same cycle -> 8 codes each dispatched exactly once, no lost results, done after last consumption.
REQ-036 n=0 -> done 2 cycles after go, best_len=0, no worker_start.
REQ-037 Reset asserted after 5 starts of an n=8 run -> outputs at reset values next cycle; new go with n=1 runs cleanly to done.
REQ-038 Spurious worker_complete[2] while worker 2 idle, plus go during busy -> both ignored; result matches a clean run.
REQ-039 n=8, random worker latencies 1..20 -> 256 unique codes dispatched, best matches reference model.
